// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// SRAM-like request/response bus used on all three sides of the memory port
// arbiter (fetch, data and downstream bridge).
//
// Signals:
//   req     - request valid; held by the requester until addr_ok
//   wr      - 1 = write, 0 = read
//   size    - 0 = byte, 1 = half, 2 = word
//   addr    - byte address
//   wdata   - write data
//   addr_ok - request accepted (one-cycle pulse)
//   data_ok - read data valid / write complete (one-cycle pulse)
//   rdata   - read data, valid with data_ok
//
// Modports:
//   master - the side issuing requests (drives req/wr/size/addr/wdata)
//   slave  - the side serving requests (drives addr_ok/data_ok/rdata)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output wr,
    output size,
    output addr,
    output wdata,
    input  addr_ok,
    input  data_ok,
    input  rdata
  );

  modport slave (
    input  req,
    input  wr,
    input  size,
    input  addr,
    input  wdata,
    output addr_ok,
    output data_ok,
    output rdata
  );

endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one SRAM-like memory port between instruction fetch (read-only) and
// data load/store. At most one transaction is outstanding. A request is
// accepted in IDLE (addr_ok pulses combinationally in that cycle), its fields
// are latched into the downstream registers, and the downstream response is
// routed back only to the port that owns the transaction.
//
// Parameters:
//   ADDR_W - address width of all ports
//   DATA_W - data width of all ports
//
// Ports:
//   clk    - clock
//   reset  - asynchronous, active-high reset
//   i_bus  - fetch port (slave side); wr/size/wdata are ignored, fetches
//            always go downstream as word reads
//   d_bus  - data port (slave side)
//   m_bus  - downstream port towards the memory bridge (master side)
//   busy   - a transaction is outstanding (FSM not in IDLE)
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN - when defined, simultaneous fetch and data
//   requests alternate using a last-grant register. When undefined, data
//   always wins and the last-grant register does not exist.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  i_bus,
  mem_port_arbiter_if.slave  d_bus,
  mem_port_arbiter_if.master m_bus,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  // Owner / grant encoding shared by the owner and last-grant registers.
  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  localparam logic [1:0] SIZE_WORD = 2'd2;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              m_req_q, m_req_d;
  logic              m_wr_q, m_wr_d;
  logic [1:0]        m_size_q, m_size_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;

  logic              grant_data;
  logic              i_addr_ok_c;
  logic              d_addr_ok_c;
  logic              resp_done;

  // Fetch requests carry no write information; keep the pins referenced so
  // the interface stays uniform across all three ports.
  logic              unused_fetch_fields;
  assign unused_fetch_fields = ^{i_bus.wr, i_bus.size, i_bus.wdata};

  // -------------------------------------------------------------------------
  // Winner selection (only meaningful in IDLE with at least one request)
  // -------------------------------------------------------------------------
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  // On a tie the port that was not granted last time wins; a lone
  // requester always wins regardless of history.
  always_comb begin
    grant_data = d_bus.req && (!i_bus.req || (last_grant_q == OWNER_FETCH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= OWNER_DATA;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  always_comb begin
    grant_data = d_bus.req;
  end
`endif

  // -------------------------------------------------------------------------
  // State and downstream request registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWNER_DATA;
      m_req_q   <= 1'b0;
      m_wr_q    <= 1'b0;
      m_size_q  <= 2'd0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      m_req_q   <= m_req_d;
      m_wr_q    <= m_wr_d;
      m_size_q  <= m_size_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    m_req_d     = m_req_q;
    m_wr_d      = m_wr_q;
    m_size_d    = m_size_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    i_addr_ok_c = 1'b0;
    d_addr_ok_c = 1'b0;
    resp_done   = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    unique case (state_q)
      IDLE: begin
        // Acceptance is suppressed while reset is held so that no addr_ok
        // pulse escapes during an asynchronous reset.
        if (!reset && (i_bus.req || d_bus.req)) begin
          state_d = ADDR;
          m_req_d = 1'b1;
          if (grant_data) begin
            d_addr_ok_c = 1'b1;
            owner_d     = OWNER_DATA;
            m_wr_d      = d_bus.wr;
            m_size_d    = d_bus.size;
            m_addr_d    = d_bus.addr;
            m_wdata_d   = d_bus.wdata;
          end else begin
            i_addr_ok_c = 1'b1;
            owner_d     = OWNER_FETCH;
            m_wr_d      = 1'b0;
            m_size_d    = SIZE_WORD;
            m_addr_d    = i_bus.addr;
            m_wdata_d   = '0;
          end
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = owner_d;
`endif
        end
      end

      ADDR: begin
        // A data_ok without addr_ok here is a stray response and ignored.
        if (m_bus.addr_ok) begin
          m_req_d = 1'b0;
          if (m_bus.data_ok) begin
            resp_done = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d   = DATA;
          end
        end
      end

      DATA: begin
        if (m_bus.data_ok) begin
          resp_done = 1'b1;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output wiring
  // -------------------------------------------------------------------------
  assign i_bus.addr_ok = i_addr_ok_c;
  assign d_bus.addr_ok = d_addr_ok_c;
  assign i_bus.data_ok = resp_done && (owner_q == OWNER_FETCH);
  assign d_bus.data_ok = resp_done && (owner_q == OWNER_DATA);

  // Read data is a straight pass-through; only the data_ok qualifies it.
  assign i_bus.rdata   = m_bus.rdata;
  assign d_bus.rdata   = m_bus.rdata;

  assign m_bus.req     = m_req_q;
  assign m_bus.wr      = m_wr_q;
  assign m_bus.size    = m_size_q;
  assign m_bus.addr    = m_addr_q;
  assign m_bus.wdata   = m_wdata_q;

  assign busy          = (state_q != IDLE);

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed scenarios followed by a randomized run checked against a
// transaction-level model of the arbiter. Inputs change on the falling
// edge; outputs are sampled 1 ns later, well before the next rising edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic reset;
  logic busy;

  int tests_run;
  int tests_failed;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ibus ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dbus ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mbus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .i_bus (ibus),
    .d_bus (dbus),
    .m_bus (mbus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr_inputs();
    ibus.req = 0; ibus.wr = 0; ibus.size = 0; ibus.addr = '0; ibus.wdata = '0;
    dbus.req = 0; dbus.wr = 0; dbus.size = 0; dbus.addr = '0; dbus.wdata = '0;
    mbus.addr_ok = 0; mbus.data_ok = 0; mbus.rdata = '0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    clr_inputs();
    @(negedge clk); @(negedge clk); #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b expected 0", busy); end
    tests_run++; if (mbus.req !== 1'b0) begin tests_failed++; $display("FAIL rst_mreq: got %b expected 0", mbus.req); end
    tests_run++; if ({mbus.wr, mbus.size, mbus.addr, mbus.wdata} !== '0) begin tests_failed++; $display("FAIL rst_mfields: got %h/%h/%h/%h expected 0", mbus.wr, mbus.size, mbus.addr, mbus.wdata); end
    tests_run++; if ({ibus.addr_ok, dbus.addr_ok, ibus.data_ok, dbus.data_ok} !== 4'b0) begin tests_failed++; $display("FAIL rst_oks: got %b expected 0000", {ibus.addr_ok, dbus.addr_ok, ibus.data_ok, dbus.data_ok}); end
    @(negedge clk); reset = 1'b0;
    $display("[TB] reset done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_single_fetch();
    // cycle 0: request accepted immediately
    @(negedge clk); ibus.req = 1; ibus.addr = 32'hBFC0_0000; ibus.wr = 1; ibus.size = 0; #1;
    tests_run++; if (ibus.addr_ok !== 1'b1) begin tests_failed++; $display("FAIL sf_iaok: got %b expected 1", ibus.addr_ok); end
    tests_run++; if (dbus.addr_ok !== 1'b0) begin tests_failed++; $display("FAIL sf_daok: got %b expected 0", dbus.addr_ok); end
    // cycle 1: downstream request with fetch fields
    @(negedge clk); ibus.req = 0; #1;
    tests_run++; if ({mbus.req, mbus.addr} !== {1'b1, 32'hBFC0_0000}) begin tests_failed++; $display("FAIL sf_c1_mreq: got %b/%h expected 1/bfc00000", mbus.req, mbus.addr); end
    tests_run++; if ({mbus.wr, mbus.size} !== 3'b0_10) begin tests_failed++; $display("FAIL sf_wr_size: got %b/%0d expected 0/2", mbus.wr, mbus.size); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL sf_busy1: got %b expected 1", busy); end
    // cycle 2: downstream accepts
    @(negedge clk); mbus.addr_ok = 1; #1;
    tests_run++; if ({mbus.req, mbus.addr} !== {1'b1, 32'hBFC0_0000}) begin tests_failed++; $display("FAIL sf_c2_mreq: got %b/%h expected 1/bfc00000", mbus.req, mbus.addr); end
    // cycle 3: waiting for data, request dropped
    @(negedge clk); mbus.addr_ok = 0; #1;
    tests_run++; if ({mbus.req, ibus.data_ok} !== 2'b00) begin tests_failed++; $display("FAIL sf_c3: got mreq=%b idok=%b expected 0/0", mbus.req, ibus.data_ok); end
    // cycle 4: response
    @(negedge clk); mbus.data_ok = 1; mbus.rdata = 32'h3C08_0001; #1;
    tests_run++; if ({ibus.data_ok, ibus.rdata} !== {1'b1, 32'h3C08_0001}) begin tests_failed++; $display("FAIL sf_resp: got %b/%h expected 1/3c080001", ibus.data_ok, ibus.rdata); end
    tests_run++; if (dbus.data_ok !== 1'b0) begin tests_failed++; $display("FAIL sf_dd_nonowner: got %b expected 0", dbus.data_ok); end
    // cycle 5: idle again
    @(negedge clk); mbus.data_ok = 0; #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL sf_busy5: got %b expected 0", busy); end
    $display("[TB] single fetch addr=bfc00000 rdata=3c080001");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_simultaneous();
    @(negedge clk);
    ibus.req = 1; ibus.addr = 32'hBFC0_0004;
    dbus.req = 1; dbus.wr = 1; dbus.size = 2; dbus.addr = 32'h8000_1000; dbus.wdata = 32'hDEAD_BEEF; #1;
    // last grant was fetch, so both builds pick data here
    tests_run++; if ({dbus.addr_ok, ibus.addr_ok} !== 2'b10) begin tests_failed++; $display("FAIL sim_grant: got d=%b i=%b expected d=1 i=0", dbus.addr_ok, ibus.addr_ok); end
    @(negedge clk); dbus.req = 0; mbus.addr_ok = 1; #1;
    tests_run++; if ({mbus.req, mbus.wr, mbus.size} !== 4'b1_1_10) begin tests_failed++; $display("FAIL sim_mctl: got %b/%b/%0d expected 1/1/2", mbus.req, mbus.wr, mbus.size); end
    tests_run++; if ({mbus.addr, mbus.wdata} !== {32'h8000_1000, 32'hDEAD_BEEF}) begin tests_failed++; $display("FAIL sim_mfields: got %h/%h expected 80001000/deadbeef", mbus.addr, mbus.wdata); end
    tests_run++; if (ibus.addr_ok !== 1'b0) begin tests_failed++; $display("FAIL sim_loser: got %b expected 0", ibus.addr_ok); end
    @(negedge clk); mbus.addr_ok = 0; mbus.data_ok = 1; #1;
    tests_run++; if ({dbus.data_ok, ibus.data_ok, ibus.addr_ok} !== 3'b100) begin tests_failed++; $display("FAIL sim_dresp: got dd=%b id=%b ia=%b expected 1/0/0", dbus.data_ok, ibus.data_ok, ibus.addr_ok); end
    @(negedge clk); mbus.data_ok = 0; #1;
    tests_run++; if (ibus.addr_ok !== 1'b1) begin tests_failed++; $display("FAIL sim_fetch_next: got %b expected 1", ibus.addr_ok); end
    @(negedge clk); ibus.req = 0; mbus.addr_ok = 1; mbus.data_ok = 1; mbus.rdata = 32'h1234_5678; #1;
    tests_run++; if ({mbus.addr, mbus.wr, ibus.data_ok, ibus.rdata} !== {32'hBFC0_0004, 1'b0, 1'b1, 32'h1234_5678}) begin tests_failed++; $display("FAIL sim_fetch_done: got %h/%b/%b/%h expected bfc00004/0/1/12345678", mbus.addr, mbus.wr, ibus.data_ok, ibus.rdata); end
    @(negedge clk); mbus.addr_ok = 0; mbus.data_ok = 0;
    $display("[TB] simultaneous: store 80001000 then fetch bfc00004");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_priority();
    logic exp_i;
    @(negedge clk);
    ibus.req = 1; ibus.addr = 32'h0000_0100;
    dbus.req = 1; dbus.wr = 0; dbus.size = 1; dbus.addr = 32'h0000_0200; #1;
    tests_run++; if ({dbus.addr_ok, ibus.addr_ok} !== 2'b10) begin tests_failed++; $display("FAIL pri_first: got d=%b i=%b expected d=1 i=0", dbus.addr_ok, ibus.addr_ok); end
    // data port immediately queues another request; complete the first
    @(negedge clk); dbus.addr = 32'h0000_0204; mbus.addr_ok = 1; mbus.data_ok = 1; mbus.rdata = 32'hA5A5_0001; #1;
    tests_run++; if ({dbus.data_ok, dbus.rdata, ibus.addr_ok} !== {1'b1, 32'hA5A5_0001, 1'b0}) begin tests_failed++; $display("FAIL pri_done1: got %b/%h/%b expected 1/a5a50001/0", dbus.data_ok, dbus.rdata, ibus.addr_ok); end
    // second simultaneous pair: round robin hands it to fetch
    @(negedge clk); mbus.addr_ok = 0; mbus.data_ok = 0; #1;
    exp_i = RR;
    tests_run++; if ({ibus.addr_ok, dbus.addr_ok} !== {exp_i, ~exp_i}) begin tests_failed++; $display("FAIL pri_second: got i=%b d=%b expected i=%b d=%b", ibus.addr_ok, dbus.addr_ok, exp_i, ~exp_i); end
    @(negedge clk);
    if (exp_i) ibus.req = 0; else dbus.req = 0;
    mbus.addr_ok = 1; mbus.data_ok = 1; #1;
    tests_run++; if ({ibus.data_ok, dbus.data_ok} !== {exp_i, ~exp_i}) begin tests_failed++; $display("FAIL pri_done2: got i=%b d=%b expected i=%b d=%b", ibus.data_ok, dbus.data_ok, exp_i, ~exp_i); end
    // remaining requester is now alone and must be served
    @(negedge clk); mbus.addr_ok = 0; mbus.data_ok = 0; #1;
    tests_run++; if ({ibus.addr_ok, dbus.addr_ok} !== {~exp_i, exp_i}) begin tests_failed++; $display("FAIL pri_third: got i=%b d=%b expected i=%b d=%b", ibus.addr_ok, dbus.addr_ok, ~exp_i, exp_i); end
    @(negedge clk); ibus.req = 0; dbus.req = 0; mbus.addr_ok = 1; mbus.data_ok = 1;
    @(negedge clk); mbus.addr_ok = 0; mbus.data_ok = 0;
    $display("[TB] priority: second pair winner=%s", exp_i ? "fetch" : "data");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    @(negedge clk); dbus.req = 1; dbus.wr = 0; dbus.size = 0; dbus.addr = 32'h0000_0033; #1;
    tests_run++; if (dbus.addr_ok !== 1'b1) begin tests_failed++; $display("FAIL b2b_acc: got %b expected 1", dbus.addr_ok); end
    @(negedge clk); dbus.req = 0; mbus.addr_ok = 1; mbus.data_ok = 1; mbus.rdata = 32'h0000_00EE; #1;
    tests_run++; if ({dbus.data_ok, dbus.rdata, mbus.size} !== {1'b1, 32'h0000_00EE, 2'd0}) begin tests_failed++; $display("FAIL b2b_comb: got %b/%h/%0d expected 1/000000ee/0", dbus.data_ok, dbus.rdata, mbus.size); end
    @(negedge clk); mbus.addr_ok = 0; mbus.data_ok = 0; ibus.req = 1; ibus.addr = 32'h0000_0040; #1;
    tests_run++; if ({busy, ibus.addr_ok} !== 2'b01) begin tests_failed++; $display("FAIL b2b_next: got busy=%b ia=%b expected 0/1", busy, ibus.addr_ok); end
    @(negedge clk); ibus.req = 0; mbus.addr_ok = 1; mbus.data_ok = 1;
    @(negedge clk); mbus.addr_ok = 0; mbus.data_ok = 0;
    $display("[TB] back-to-back: load 00000033 then fetch 00000040");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_stray();
    @(negedge clk); mbus.data_ok = 1; mbus.addr_ok = 1; #1;
    tests_run++; if ({ibus.data_ok, dbus.data_ok} !== 2'b00) begin tests_failed++; $display("FAIL stray_pulse: got i=%b d=%b expected 0/0", ibus.data_ok, dbus.data_ok); end
    @(negedge clk); mbus.data_ok = 0; mbus.addr_ok = 0; #1;
    tests_run++; if ({busy, mbus.req} !== 2'b00) begin tests_failed++; $display("FAIL stray_state: got busy=%b mreq=%b expected 0/0", busy, mbus.req); end
    $display("[TB] stray response ignored");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid();
    @(negedge clk); dbus.req = 1; dbus.wr = 1; dbus.size = 2; dbus.addr = 32'h8000_2000; dbus.wdata = 32'hCAFE_F00D;
    @(negedge clk); dbus.req = 0; mbus.addr_ok = 1;
    @(negedge clk); mbus.addr_ok = 0; #1;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rm_indata: got busy=%b expected 1", busy); end
    @(negedge clk); reset = 1; #1;
    tests_run++; if ({busy, mbus.req, mbus.wr, mbus.size} !== 5'b0) begin tests_failed++; $display("FAIL rm_async: got busy=%b mreq=%b wr=%b size=%0d expected 0", busy, mbus.req, mbus.wr, mbus.size); end
    tests_run++; if ({mbus.addr, mbus.wdata} !== 64'h0) begin tests_failed++; $display("FAIL rm_fields: got %h/%h expected 0/0", mbus.addr, mbus.wdata); end
    @(negedge clk); reset = 0;
    @(negedge clk); mbus.data_ok = 1; #1;
    tests_run++; if ({ibus.data_ok, dbus.data_ok, busy} !== 3'b000) begin tests_failed++; $display("FAIL rm_late: got i=%b d=%b busy=%b expected 0/0/0", ibus.data_ok, dbus.data_ok, busy); end
    @(negedge clk); mbus.data_ok = 0;
    $display("[TB] reset mid-transaction dropped store 80002000");
  endtask

  // -------------------------------------------------------------------------
  // Randomized run. The model tracks transactions, not FSM states: a port
  // owns the memory from its acceptance until its response, the response is
  // only valid once the downstream has taken the address, and ties are
  // resolved by data priority or by alternation.
  task automatic test_random();
    logic          mdl_busy, mdl_owner, mdl_addr_taken, mdl_last;
    logic          mdl_wr;
    logic [1:0]    mdl_size;
    logic [AW-1:0] mdl_addr;
    logic [DW-1:0] mdl_wdata;
    logic          accept, win_d, resp_now, exp_mreq;
    logic          i_taken, d_taken;
    int            resp_phase, n_done;

    reset = 1; clr_inputs();
    @(negedge clk); reset = 0;
    mdl_busy = 0; mdl_owner = 1; mdl_addr_taken = 0; mdl_last = 1;
    mdl_wr = 0; mdl_size = 0; mdl_addr = '0; mdl_wdata = '0;
    i_taken = 0; d_taken = 0; resp_phase = 0; n_done = 0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (i_taken) ibus.req = 0;
      if (d_taken) dbus.req = 0;
      if (!ibus.req && $urandom_range(0, 2) == 0) begin
        ibus.req = 1; ibus.addr = $urandom(); ibus.wr = 1'($urandom());
        ibus.size = 2'($urandom_range(0, 1)); ibus.wdata = $urandom();
      end
      if (!dbus.req && $urandom_range(0, 2) == 0) begin
        dbus.req = 1; dbus.addr = $urandom(); dbus.wr = 1'($urandom());
        dbus.size = 2'($urandom_range(0, 2)); dbus.wdata = $urandom();
      end
      mbus.addr_ok = 0; mbus.data_ok = 0; mbus.rdata = $urandom();
      if (resp_phase == 0 && mbus.req) resp_phase = 1;
      if (resp_phase == 1) begin
        if ($urandom_range(0, 2) == 0) begin
          mbus.addr_ok = 1; mbus.data_ok = 1'($urandom());
        end else if ($urandom_range(0, 5) == 0) begin
          mbus.data_ok = 1;
        end
      end else if (resp_phase == 2) begin
        if ($urandom_range(0, 2) == 0) mbus.data_ok = 1;
        else if ($urandom_range(0, 5) == 0) mbus.addr_ok = 1;
      end else begin
        if ($urandom_range(0, 7) == 0) mbus.data_ok = 1;
        if ($urandom_range(0, 7) == 0) mbus.addr_ok = 1;
      end
      #1;
      accept   = !mdl_busy && (ibus.req || dbus.req);
      win_d    = dbus.req && (!ibus.req || !RR || (mdl_last == 1'b0));
      resp_now = mdl_busy && mbus.data_ok && (mdl_addr_taken || mbus.addr_ok);
      exp_mreq = mdl_busy && !mdl_addr_taken;

      tests_run++; if ({ibus.addr_ok, dbus.addr_ok} !== {accept && !win_d, accept && win_d}) begin tests_failed++; $display("FAIL rnd_addr_ok c%0d: got i=%b d=%b expected i=%b d=%b", cyc, ibus.addr_ok, dbus.addr_ok, accept && !win_d, accept && win_d); end
      tests_run++; if ({ibus.data_ok, dbus.data_ok} !== {resp_now && !mdl_owner, resp_now && mdl_owner}) begin tests_failed++; $display("FAIL rnd_data_ok c%0d: got i=%b d=%b expected i=%b d=%b", cyc, ibus.data_ok, dbus.data_ok, resp_now && !mdl_owner, resp_now && mdl_owner); end
      tests_run++; if ({busy, mbus.req} !== {mdl_busy, exp_mreq}) begin tests_failed++; $display("FAIL rnd_busy_mreq c%0d: got %b/%b expected %b/%b", cyc, busy, mbus.req, mdl_busy, exp_mreq); end
      if (exp_mreq) begin
        tests_run++; if ({mbus.wr, mbus.size, mbus.addr} !== {mdl_wr, mdl_size, mdl_addr}) begin tests_failed++; $display("FAIL rnd_mfields c%0d: got %b/%0d/%h expected %b/%0d/%h", cyc, mbus.wr, mbus.size, mbus.addr, mdl_wr, mdl_size, mdl_addr); end
        if (mdl_owner) begin
          tests_run++; if (mbus.wdata !== mdl_wdata) begin tests_failed++; $display("FAIL rnd_wdata c%0d: got %h expected %h", cyc, mbus.wdata, mdl_wdata); end
        end
      end
      if (resp_now) begin
        tests_run++; if ((mdl_owner ? dbus.rdata : ibus.rdata) !== mbus.rdata) begin tests_failed++; $display("FAIL rnd_rdata c%0d: got %h expected %h", cyc, mdl_owner ? dbus.rdata : ibus.rdata, mbus.rdata); end
        n_done++;
        $display("[TB] rnd txn %0d %s %s addr=%h", n_done, mdl_owner ? "data" : "fetch", mdl_wr ? "wr" : "rd", mdl_addr);
      end

      // downstream responder follows its own handshake view
      if (resp_phase == 1 && mbus.addr_ok) resp_phase = mbus.data_ok ? 0 : 2;
      else if (resp_phase == 2 && mbus.data_ok) resp_phase = 0;
      i_taken = ibus.addr_ok;
      d_taken = dbus.addr_ok;

      if (accept) begin
        mdl_busy = 1; mdl_owner = win_d; mdl_addr_taken = 0; mdl_last = win_d;
        mdl_wr    = win_d ? dbus.wr : 1'b0;
        mdl_size  = win_d ? dbus.size : 2'd2;
        mdl_addr  = win_d ? dbus.addr : ibus.addr;
        mdl_wdata = dbus.wdata;
      end else if (mdl_busy) begin
        if (mbus.addr_ok) mdl_addr_taken = 1;
        if (resp_now) mdl_busy = 0;
      end
    end
    @(negedge clk); clr_inputs();
    tests_run++; if (n_done < 20) begin tests_failed++; $display("FAIL rnd_progress: got %0d transactions expected at least 20", n_done); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_priority();
    test_back_to_back();
    test_stray();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_mem_port_arbiter
